// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack, depth tracking and sticky error flags.
// Define PC_STACK_WRAP_EN to make a call at full stack overwrite the oldest entry instead of dropping it.
module pc_call_stack #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      DEPTH      = 8,
  parameter int unsigned      STEP       = 1,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned    LW   = $clog2(DEPTH + 1);
  localparam int unsigned    PW   = $clog2(DEPTH);
  localparam logic [LW-1:0]  FULL = LW'(DEPTH);
  localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] out_q, out_d, seq_pc;
  logic [LW-1:0]    level_q, level_d;
  logic [PW-1:0]    head_q, head_d, head_inc, head_dec;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push_en;
  logic [WIDTH-1:0] stack_q [DEPTH];

  // head_q is the slot for the next push; it is handled modulo DEPTH so the
  // same pointer serves both the dropping and the circular full-stack policy.
  always_comb begin
    seq_pc   = out_q + WIDTH'(STEP);
    head_inc = (head_q == LAST) ? '0 : head_q + PW'(1);
    head_dec = (head_q == '0) ? LAST : head_q - PW'(1);
    out_d    = out_q;
    level_d  = level_q;
    head_d   = head_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_en  = 1'b0;
    if (ret) begin
      if (level_q != '0) begin
        out_d   = stack_q[head_dec];
        level_d = level_q - LW'(1);
        head_d  = head_dec;
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      out_d = in;
      if (level_q != FULL) begin
        push_en = 1'b1;
        head_d  = head_inc;
        level_d = level_q + LW'(1);
      end else begin
        ovf_d = 1'b1;
`ifdef PC_STACK_WRAP_EN
        push_en = 1'b1;
        head_d  = head_inc;
`endif
      end
    end else if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d = seq_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_q   <= RESET_ADDR;
      level_q <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      level_q <= level_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (reset && push_en) begin
      stack_q[head_q] <= seq_pc;
    end
  end

  assign out       = out_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: two instances (STEP=1/RESET_ADDR=0 and STEP=2/RESET_ADDR=0x0100)
// share stimulus and are compared every cycle against a queue-based return-stack model.
module tb_pc_call_stack;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in    = '0;
  logic        load  = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;

  logic [15:0] out0, out1;
  logic [2:0]  level0, level1;
  logic        ovf0, ovf1, unf0, unf1;

  always #5 clock = ~clock;

  pc_call_stack #(.WIDTH(16), .DEPTH(DEPTH), .STEP(1), .RESET_ADDR(16'h0000)) dut0 (
    .clock(clock), .reset(reset), .in(in), .load(load), .inc(inc), .call(call), .ret(ret),
    .out(out0), .level(level0), .overflow(ovf0), .underflow(unf0));

  pc_call_stack #(.WIDTH(16), .DEPTH(DEPTH), .STEP(2), .RESET_ADDR(16'h0100)) dut1 (
    .clock(clock), .reset(reset), .in(in), .load(load), .inc(inc), .call(call), .ret(ret),
    .out(out1), .level(level1), .overflow(ovf1), .underflow(unf1));

  typedef struct {
    logic [15:0] pc0, pc1;
    int          lv0, lv1;
    bit          ov0, ov1, un0, un1;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  // Reference model: return addresses held in plain queues, newest at the back.
  logic [15:0] mpc [2];
  bit          mov [2];
  bit          mun [2];
  logic [15:0] mstk0 [$];
  logic [15:0] mstk1 [$];

  function automatic int mdepth(int m);
    return (m == 0) ? mstk0.size() : mstk1.size();
  endfunction

  task automatic mclear(int m);
    if (m == 0) mstk0.delete(); else mstk1.delete();
  endtask

  task automatic mpush(int m, logic [15:0] v);
    if (m == 0) mstk0.push_back(v); else mstk1.push_back(v);
  endtask

  task automatic mpop(int m, output logic [15:0] v);
    if (m == 0) v = mstk0.pop_back(); else v = mstk1.pop_back();
  endtask

  task automatic mdrop_oldest(int m);
    logic [15:0] d;
    if (m == 0) d = mstk0.pop_front(); else d = mstk1.pop_front();
  endtask

  task automatic mstep(int m, int step, logic [15:0] ra,
                       bit rst_n, bit ld, bit ic, bit cl, bit rt, logic [15:0] din);
    logic [15:0] v;
    if (!rst_n) begin
      mpc[m] = ra; mov[m] = 0; mun[m] = 0; mclear(m);
    end else if (rt) begin
      if (mdepth(m) > 0) begin
        mpop(m, v);
        mpc[m] = v;
      end else begin
        mun[m] = 1;
      end
    end else if (cl) begin
      if (mdepth(m) < DEPTH) begin
        mpush(m, mpc[m] + 16'(step));
      end else begin
        mov[m] = 1;
`ifdef PC_STACK_WRAP_EN
        mdrop_oldest(m);
        mpush(m, mpc[m] + 16'(step));
`endif
      end
      mpc[m] = din;
    end else if (ld) begin
      mpc[m] = din;
    end else if (ic) begin
      mpc[m] = mpc[m] + 16'(step);
    end
  endtask

  task automatic drive(bit rst_n, bit ld, bit ic, bit cl, bit rt, logic [15:0] din);
    exp_t e;
    @(negedge clock);
    reset = rst_n; load = ld; inc = ic; call = cl; ret = rt; in = din;
    mstep(0, 1, 16'h0000, rst_n, ld, ic, cl, rt, din);
    mstep(1, 2, 16'h0100, rst_n, ld, ic, cl, rt, din);
    e.pc0 = mpc[0]; e.pc1 = mpc[1];
    e.lv0 = mdepth(0); e.lv1 = mdepth(1);
    e.ov0 = mov[0]; e.ov1 = mov[1]; e.un0 = mun[0]; e.un1 = mun[1];
    sb.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every edge presents new registered outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out0",       32'(out0),   32'(e.pc0));
        chk("level0",     32'(level0), 32'(e.lv0));
        chk("overflow0",  32'(ovf0),   32'(e.ov0));
        chk("underflow0", 32'(unf0),   32'(e.un0));
        chk("out1",       32'(out1),   32'(e.pc1));
        chk("level1",     32'(level1), 32'(e.lv1));
        chk("overflow1",  32'(ovf1),   32'(e.ov1));
        chk("underflow1", 32'(unf1),   32'(e.un1));
      end
    end
  end

  initial begin
    int budget;
    // reset held two edges, then release
    drive(0, 0, 0, 0, 0, 16'h0);
    drive(0, 0, 0, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 0, 16'h0);
    // inc x3, load, load+inc priority, hold
    repeat (3) drive(1, 0, 1, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 0, 16'd7);
    drive(1, 1, 1, 0, 0, 16'd20);
    drive(1, 0, 0, 0, 0, 16'h0);
    // silent wrap
    drive(1, 1, 0, 0, 0, 16'hFFFF);
    drive(1, 0, 1, 0, 0, 16'h0);
    // call / inc / ret / call+ret at empty
    drive(1, 1, 0, 0, 0, 16'd7);
    drive(1, 0, 0, 1, 0, 16'd100);
    drive(1, 0, 1, 0, 0, 16'h0);
    drive(1, 0, 0, 0, 1, 16'h0);
    drive(1, 0, 0, 1, 1, 16'd55);
    // five calls into a depth-4 stack, then five returns
    drive(0, 0, 0, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 0, 16'd10);
    for (int k = 2; k <= 6; k++) drive(1, 0, 0, 1, 0, 16'(10 * k));
    repeat (5) drive(1, 0, 0, 0, 1, 16'h0);
    // reset together with call at level 3
    drive(0, 0, 0, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 0, 16'd7);
    repeat (3) drive(1, 0, 0, 1, 0, 16'd7);
    drive(0, 0, 0, 1, 0, 16'd200);
    drive(1, 0, 0, 1, 0, 16'd300);
    drive(1, 0, 0, 0, 1, 16'h0);
    // randomized traffic, biased toward call/ret so full/empty are exercised
    for (int n = 0; n < 1500; n++) begin
      automatic int r = $urandom_range(0, 99);
      automatic bit rs = ($urandom_range(0, 63) != 0);
      automatic bit cl = (r < 35);
      automatic bit rt = (r >= 25 && r < 55);
      automatic bit ld = ($urandom_range(0, 3) == 0);
      automatic bit ic = ($urandom_range(0, 1) == 0);
      automatic logic [15:0] d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d = 16'hFFFF;
      drive(rs, ld, ic, cl, rt, d);
    end
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
